// File: rtl/poly_bank_reader.sv
`default_nettype none
// ============================================================================
// Module   : poly_bank_reader
// Purpose  : Streams all NBANK*DEPTH coefficients out of a set of banked
//            memories in index order n = 0..NBANK*DEPTH-1, where
//            bank = n mod NBANK and addr = n / NBANK. Read data returns one
//            cycle after the strobe, lands in a 2-entry FIFO and leaves over
//            a valid/ready output interface.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            start        - one-cycle readout request (honoured in IDLE only)
//            rd_en        - bank read strobe
//            rd_bank      - bank select for the read
//            rd_addr      - word address within the bank
//            rd_data      - bank read data, valid one cycle after rd_en
//            out_data     - coefficient word
//            out_valid    - out_data valid
//            out_ready    - sink accepts the word
//            out_index    - coefficient index of out_data
//            out_last     - out_data carries the final index
//            busy         - readout in progress (READ or DRAIN)
//            done         - one-cycle pulse after the final handshake
// Revision : 1.0 - initial release
// ============================================================================
module poly_bank_reader #(
  parameter int DW    = 256,
  parameter int NBANK = 8,
  parameter int DEPTH = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           rd_en,
  output logic [$clog2(NBANK)-1:0]       rd_bank,
  output logic [$clog2(DEPTH)-1:0]       rd_addr,
  input  logic [DW-1:0]                  rd_data,
  output logic [DW-1:0]                  out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(NBANK*DEPTH)-1:0] out_index,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int BW = $clog2(NBANK);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = BW + AW;

  // NBANK and DEPTH are powers of two, so the final index is all ones and
  // both index counters wrap back to zero on their own after the last word.
  localparam logic [NW-1:0] LAST_N = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q;
  logic [NW-1:0]   rd_n_q;        // index of the next read to issue
  logic [NW-1:0]   out_n_q;       // index of the word at the FIFO head
  logic            inflight_q;    // a read was issued last cycle
  logic [1:0]      fifo_cnt_q;
  logic            fifo_wptr_q;
  logic            fifo_rptr_q;
  logic [DW-1:0]   fifo_mem_q [2];
  logic            done_q;

  logic            pop;
  logic [1:0]      occ_after;

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;

  // Occupancy the FIFO will hold after this edge, counting the read that is
  // already in flight. Crediting this cycle's pop lets a read issue every
  // cycle while the sink keeps up, while still never overfilling two slots.
  assign occ_after = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

  // The first read goes out in the same cycle start is seen, which is what
  // puts the first word on the output two cycles after start.
  always_comb begin
    rd_en = 1'b0;
    if (!rst && (occ_after < 2'd2)) begin
      rd_en = (state_q == READ) || ((state_q == IDLE) && start);
    end
  end

  assign rd_bank   = rd_n_q[BW-1:0];
  assign rd_addr   = rd_n_q[NW-1:BW];
  assign out_data  = fifo_mem_q[fifo_rptr_q];
  assign out_index = out_n_q;
  assign out_last  = out_valid && (out_n_q == LAST_N);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // Controller, counters and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_n_q      <= '0;
      out_n_q     <= '0;
      inflight_q  <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd_en;
      fifo_cnt_q <= occ_after;

      if (rd_en) begin
        rd_n_q <= rd_n_q + NW'(1);
      end
      if (inflight_q) begin
        fifo_wptr_q <= ~fifo_wptr_q;
      end
      if (pop) begin
        fifo_rptr_q <= ~fifo_rptr_q;
        out_n_q     <= out_n_q + NW'(1);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
          end
        end
        READ: begin
          if (rd_en && (rd_n_q == LAST_N)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Data storage carries no reset; validity is tracked by fifo_cnt_q.
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      fifo_mem_q[fifo_wptr_q] <= rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_bank_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_bank_reader
// Purpose  : Directed self-checking bench for poly_bank_reader. Bank memory
//            is modelled as word = {bank, addr} with one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_bank_reader;

  localparam int DW    = 256;
  localparam int NBANK = 8;
  localparam int DEPTH = 128;
  localparam int TOTAL = NBANK * DEPTH;
  localparam int BW    = $clog2(NBANK);
  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = $clog2(TOTAL);
  localparam int BOUND = 5000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          rd_en;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [NW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;
  int dc;

  poly_bank_reader #(.DW(DW), .NBANK(NBANK), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_bank   (rd_bank),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Preloaded banks: each word holds its own {bank, addr}.
  always @(posedge clk) begin
    if (rd_en) rd_data <= DW'({rd_bank, rd_addr});
  end

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int n);
    logic [BW-1:0] b;
    logic [AW-1:0] a;
    b = BW'(n % NBANK);
    a = AW'(n / NBANK);
    return DW'({b, a});
  endfunction

  // mode 0: always ready, 1: random ~50%, 2: stalled for 20 cycles after start
  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return (cyc > 20);
    return 1'b1;
  endfunction

  // Consumes one readout. Cycle 0 is the cycle start is high. Returns at the
  // negedge of the done cycle (done_cyc = that cycle) or, when stop_at is
  // reached with valid data, at that negedge with done_cyc = -1.
  task automatic consume(input int mode, input int restart_at, input int stop_at,
                         input bit chain, input bit skip_first, output int done_cyc);
    int cyc;
    int n;
    int last_cyc;
    int n_rd;
    bit start_next;
    cyc        = 0;
    n          = 0;
    last_cyc   = -1;
    n_rd       = skip_first ? 1 : 0;
    start_next = 1'b0;
    done_cyc   = -1;
    out_ready  = ready_for(mode, 0);
    forever begin
      if (!(skip_first && cyc == 0)) begin
        @(negedge clk);
        if (rd_en) n_rd++;
        chk_b("busy", busy, (cyc >= 1) && (last_cyc < 0 || cyc <= last_cyc));
        chk_b("done", done, (last_cyc >= 0) && (cyc == last_cyc + 1));
        if (mode == 0)
          chk_b("valid_no_bubble", out_valid, (cyc >= 2) && (last_cyc < 0 || cyc <= last_cyc));
        if (mode == 2 && cyc <= 20) chk_b("stall_valid", out_valid, cyc >= 2);
        if (mode == 2 && cyc == 20) chk_b("stall_rd_cnt_le2", n_rd <= 2, 1'b1);
        if (last_cyc >= 0 && cyc == last_cyc + 1) begin
          done_cyc = cyc;
          if (mode == 0) chk_i("cycles_start_to_done", cyc, TOTAL + 2);
          if (chain) chk_b("chain_start_rd_en", rd_en, 1'b1);
          break;
        end
        if (out_valid) begin
          chk_w("index", DW'(out_index), DW'(n));
          chk_w("data", out_data, exp_word(n));
          chk_b("last", out_last, n == TOTAL - 1);
          if (n == 9) chk_w("data_n9", out_data, 256'h81);
          if (n == stop_at) break;
          if (n == restart_at && out_ready) start_next = 1'b1;
          if (out_ready) begin
            if (n == TOTAL - 1) begin
              last_cyc = cyc;
              chk_i("rd_en_count", n_rd, TOTAL);
              if (chain) start_next = 1'b1;
            end
            n++;
          end
        end else begin
          chk_b("last_when_idle", out_last, 1'b0);
        end
      end
      if (cyc >= BOUND) begin
        chk_b("stream_within_bound", last_cyc >= 0, 1'b1);
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      start      = start_next;
      start_next = 1'b0;
      out_ready  = ready_for(mode, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk_b({tag, "_valid"}, out_valid, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
    chk_b({tag, "_rd_en"}, rd_en, 1'b0);
    chk_b({tag, "_last"}, out_last, 1'b0);
    chk_w({tag, "_index"}, DW'(out_index), '0);
    chk_w({tag, "_rd_bank"}, DW'(rd_bank), '0);
    chk_w({tag, "_rd_addr"}, DW'(rd_addr), '0);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Full stream, sink always ready
    pulse_start();
    consume(0, -1, -1, 1'b0, 1'b0, dc);
    chk_b("A_completed", dc > 0, 1'b1);
    repeat (3) @(posedge clk);

    // Random backpressure
    pulse_start();
    consume(1, -1, -1, 1'b0, 1'b0, dc);
    chk_b("B_completed", dc > 0, 1'b1);
    repeat (3) @(posedge clk);

    // Sink stalled for 20 cycles after start
    pulse_start();
    consume(2, -1, -1, 1'b0, 1'b0, dc);
    chk_b("C_completed", dc > 0, 1'b1);
    repeat (3) @(posedge clk);

    // Reset mid-stream at n=500, then restart from n=0
    pulse_start();
    consume(0, -1, 500, 1'b0, 1'b0, dc);
    chk_i("D_stopped_at_500", dc, -1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_b("abort_no_done", done, 1'b0);
      chk_b("abort_not_busy", busy, 1'b0);
    end
    pulse_start();
    consume(0, -1, -1, 1'b0, 1'b0, dc);
    chk_b("D_restart_completed", dc > 0, 1'b1);
    repeat (3) @(posedge clk);

    // Start while busy at n=100 is ignored; start coincident with done chains
    pulse_start();
    consume(0, 100, -1, 1'b1, 1'b0, dc);
    chk_b("E_first_completed", dc > 0, 1'b1);
    consume(0, -1, -1, 1'b0, 1'b1, dc);
    chk_b("E_second_completed", dc > 0, 1'b1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/poly_bank_reader.md
POLY_BANK_READER -- requirements
Module: poly_bank_reader

Interface
REQ-001 Parameter DW, default 256, coefficient width in bits.
REQ-002 Parameter NBANK, default 8, number of coefficient banks; power of two.
REQ-003 Parameter DEPTH, default 128, words per bank; power of two.
REQ-004 The block SHALL use one clock `clk` and one reset `rst`; reset is synchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin readout
- rd_en  out  1  bank read strobe
- rd_bank  out  log2(NBANK)  bank select
- rd_addr  out  log2(DEPTH)  word address within bank
- rd_data  in  DW  bank read data, valid exactly 1 cycle after rd_en
- out_data  out  DW  coefficient word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts word
- out_index  out  log2(NBANK*DEPTH)  coefficient index of out_data
- out_last  out  1  marks index NBANK*DEPTH-1
- busy  out  1  readout in progress
- done  out  1  one-cycle pulse, readout complete

Function
REQ-006 The block SHALL stream all NBANK*DEPTH coefficients in index order n = 0..NBANK*DEPTH-1, where bank = n mod NBANK, addr = n / NBANK.
REQ-007 States SHALL be IDLE, READ, DRAIN; IDLE->READ on start; READ->DRAIN after the last rd_en is issued; DRAIN->IDLE on the out_valid&out_ready handshake with out_last=1.
REQ-008 start SHALL be ignored unless the state is IDLE.
REQ-009 busy SHALL be 1 in READ and DRAIN, 0 in IDLE.
REQ-010 A word transfers only on a cycle with out_valid=1 and out_ready=1; out_data, out_index and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-011 Read data SHALL be captured in an internal 2-entry FIFO; rd_en SHALL assert only when FIFO occupancy plus in-flight reads is less than 2, so no word is ever dropped or duplicated.
REQ-012 rd_en SHALL issue exactly NBANK*DEPTH times per readout; rd_bank and rd_addr are don't-care when rd_en=0.
REQ-013 Latency: with out_ready held at 1, out_valid SHALL first assert 2 cycles after the start cycle. Output SHALL then be 1 word per cycle with no bubbles; the last word appears NBANK*DEPTH+1 cycles after start.
REQ-014 out_last SHALL equal 1 exactly when out_valid=1 and out_index=NBANK*DEPTH-1.
REQ-015 done SHALL pulse for 1 cycle, on the cycle after the final handshake; busy is 0 on that cycle.
REQ-016 A start arriving in the same cycle as done SHALL be accepted and begin a new readout.
REQ-017 out_ready may toggle arbitrarily, including during the DRAIN state, without loss or reordering.
REQ-018 The index and address counters SHALL wrap cleanly: bank increments 0..NBANK-1, then addr increments; there is no wrap beyond DEPTH-1.

Reset
REQ-019 When rst=1 at a clock edge:
- state SHALL become IDLE
- the FIFO SHALL be emptied and in-flight reads discarded
- out_valid, out_last, rd_en, busy and done SHALL be 0
- out_index, rd_bank and rd_addr SHALL be 0
REQ-020 A reset during READ or DRAIN SHALL abort the readout; no done pulse follows, and the next start restarts from n=0.

Verification
REQ-021 Banks preloaded with word = {bank, addr}, start pulsed, out_ready=1. Required:
- 1024 words arrive in order, out_data for n=9 = {1,1}
- out_last on n=1023
- done 1 cycle later
- total 1026 cycles from start to done
REQ-022 out_ready driven by a random pattern (about 50% duty). Required:
- sequence and data identical to REQ-021
- out_data stable during every stall
- rd_en count = 1024
REQ-023 out_ready held at 0 for 20 cycles after start. Required:
- at most 2 rd_en issued
- out_valid=1 with out_index=0 held throughout
- full stream resumes when out_ready rises
REQ-024 rst asserted at n=500 mid-stream. Required:
- next cycle out_valid=0 and busy=0, no done pulse
- a new start yields n=0 first
REQ-025 start pulsed while busy at n=100, then start coincident with done. Required:
- the first start is ignored with no index disturbance
- the second start is accepted, with a second 1024-word stream beginning at n=0
